// File: rtl/inet_checksum.sv
// RFC 1071 ones'-complement checksum engine with an AXI-Stream input, an optional
// seed beat carrying a pseudo-header partial sum, and one 16-bit result beat per packet.
module inet_checksum #(
  parameter int unsigned AXIS_BYTES = 2,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter bit          USE_SEED   = 1'b0,
  parameter bit          ZERO_SUB   = 1'b0
) (
  input  logic                    clk,
  input  logic                    sresetn,
  input  logic                    seed_tvalid,
  output logic                    seed_tready,
  input  logic [15:0]             seed_tdata,
  input  logic                    axis_i_tvalid,
  output logic                    axis_i_tready,
  input  logic                    axis_i_tlast,
  input  logic [AXIS_BYTES-1:0]   axis_i_tkeep,
  input  logic [8*AXIS_BYTES-1:0] axis_i_tdata,
  output logic                    axis_o_tvalid,
  input  logic                    axis_o_tready,
  output logic                    axis_o_tlast,
  output logic [15:0]             axis_o_tdata
);

  localparam int unsigned DW = 8 * AXIS_BYTES;
  localparam int unsigned NW = AXIS_BYTES / 2;
  localparam int unsigned AW = 32;
  // Up to eight 16-bit words per beat: the beat sum needs at most 19 bits.
  localparam int unsigned SW = 20;

  typedef enum logic [2:0] {
    ST_SEED  = 3'd0,
    ST_CALC  = 3'd1,
    ST_FOLD1 = 3'd2,
    ST_FOLD2 = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  localparam state_t ST_START = USE_SEED ? ST_SEED : ST_CALC;

  state_t          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic            seed_tready_q, seed_tready_d;
  logic            i_tready_q, i_tready_d;
  logic            o_tvalid_q, o_tvalid_d;
  logic [15:0]     o_tdata_q, o_tdata_d;
  logic [SW-1:0]   beat_sum;

  // Byte idx of the current beat in stream order, zeroed when its keep bit is clear.
  function automatic logic [7:0] lane(input logic [DW-1:0]         d,
                                      input logic [AXIS_BYTES-1:0] k,
                                      input int unsigned           idx);
    logic [7:0] b;
    if (MSB_FIRST) b = d[DW-1-8*idx -: 8];
    else           b = d[8*idx +: 8];
    return k[idx] ? b : 8'h00;
  endfunction

  // Final complement, with the optional UDP substitution of an all-zero result.
  function automatic logic [15:0] finish_sum(input logic [15:0] s);
    logic [15:0] r;
    r = ~s;
    if (ZERO_SUB && (r == 16'h0000)) r = 16'hFFFF;
    return r;
  endfunction

  // Sum of the big-endian 16-bit words of one beat; a missing odd byte reads as zero.
  always_comb begin
    beat_sum = '0;
    for (int unsigned j = 0; j < NW; j++) begin
      beat_sum = beat_sum + SW'({lane(axis_i_tdata, axis_i_tkeep, 2*j),
                                 lane(axis_i_tdata, axis_i_tkeep, 2*j + 1)});
    end
  end

  // Next state, accumulator update and registered-output decode.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    case (state_q)
      ST_SEED: begin
        if (seed_tvalid) begin
          acc_d   = AW'(seed_tdata);
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (axis_i_tvalid) begin
          // Partial fold each beat keeps the 32-bit accumulator from overflowing.
          acc_d = AW'(acc_q[31:16]) + AW'(acc_q[15:0]) + AW'(beat_sum);
          if (axis_i_tlast) state_d = ST_FOLD1;
        end
      end
      ST_FOLD1: begin
        acc_d   = AW'(acc_q[31:16]) + AW'(acc_q[15:0]);
        state_d = ST_FOLD2;
      end
      ST_FOLD2: begin
        acc_d   = AW'(acc_q[31:16]) + AW'(acc_q[15:0]);
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (axis_o_tready) begin
          acc_d   = '0;
          state_d = ST_START;
        end
      end
      default: begin
        acc_d   = '0;
        state_d = ST_START;
      end
    endcase

    // Readies and valid are decodes of the next state, so they carry no path from tvalid/tready.
    seed_tready_d = USE_SEED && (state_d == ST_SEED);
    i_tready_d    = (state_d == ST_CALC);
    o_tvalid_d    = (state_d == ST_OUT);
    o_tdata_d     = finish_sum(acc_d[15:0]);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state_q       <= ST_START;
      acc_q         <= '0;
      seed_tready_q <= USE_SEED && (ST_START == ST_SEED);
      i_tready_q    <= (ST_START == ST_CALC);
      o_tvalid_q    <= 1'b0;
      o_tdata_q     <= finish_sum(16'h0000);
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      seed_tready_q <= seed_tready_d;
      i_tready_q    <= i_tready_d;
      o_tvalid_q    <= o_tvalid_d;
      o_tdata_q     <= o_tdata_d;
    end
  end

  assign seed_tready   = seed_tready_q;
  assign axis_i_tready = i_tready_q;
  assign axis_o_tvalid = o_tvalid_q;
  assign axis_o_tdata  = o_tdata_q;
  assign axis_o_tlast  = 1'b1;

endmodule

// File: tb/tb_inet_checksum.sv
// Directed and randomised bench for inet_checksum across three parameter sets.
`timescale 1ns/1ps
module tb_inet_checksum;

  logic clk = 1'b0;
  logic sresetn;
  always #5 clk = ~clk;

  // Instance A: 2-byte beats, MSB first, no seed, no zero substitution.
  logic a_seed_tvalid, a_seed_tready, a_i_tvalid, a_i_tready, a_i_tlast;
  logic a_o_tvalid, a_o_tready, a_o_tlast;
  logic [15:0] a_seed_tdata, a_i_tdata, a_o_tdata;
  logic [1:0]  a_i_tkeep;
  // Instance B: 2-byte beats, MSB first, seeded, zero substitution.
  logic b_seed_tvalid, b_seed_tready, b_i_tvalid, b_i_tready, b_i_tlast;
  logic b_o_tvalid, b_o_tready, b_o_tlast;
  logic [15:0] b_seed_tdata, b_i_tdata, b_o_tdata;
  logic [1:0]  b_i_tkeep;
  // Instance C: 8-byte beats, LSB first, no seed.
  logic c_seed_tvalid, c_seed_tready, c_i_tvalid, c_i_tready, c_i_tlast;
  logic c_o_tvalid, c_o_tready, c_o_tlast;
  logic [15:0] c_seed_tdata, c_o_tdata;
  logic [63:0] c_i_tdata;
  logic [7:0]  c_i_tkeep;

  inet_checksum #(.AXIS_BYTES(2), .MSB_FIRST(1'b1), .USE_SEED(1'b0), .ZERO_SUB(1'b0)) u_a (
    .clk(clk), .sresetn(sresetn),
    .seed_tvalid(a_seed_tvalid), .seed_tready(a_seed_tready), .seed_tdata(a_seed_tdata),
    .axis_i_tvalid(a_i_tvalid), .axis_i_tready(a_i_tready), .axis_i_tlast(a_i_tlast),
    .axis_i_tkeep(a_i_tkeep), .axis_i_tdata(a_i_tdata),
    .axis_o_tvalid(a_o_tvalid), .axis_o_tready(a_o_tready), .axis_o_tlast(a_o_tlast),
    .axis_o_tdata(a_o_tdata));

  inet_checksum #(.AXIS_BYTES(2), .MSB_FIRST(1'b1), .USE_SEED(1'b1), .ZERO_SUB(1'b1)) u_b (
    .clk(clk), .sresetn(sresetn),
    .seed_tvalid(b_seed_tvalid), .seed_tready(b_seed_tready), .seed_tdata(b_seed_tdata),
    .axis_i_tvalid(b_i_tvalid), .axis_i_tready(b_i_tready), .axis_i_tlast(b_i_tlast),
    .axis_i_tkeep(b_i_tkeep), .axis_i_tdata(b_i_tdata),
    .axis_o_tvalid(b_o_tvalid), .axis_o_tready(b_o_tready), .axis_o_tlast(b_o_tlast),
    .axis_o_tdata(b_o_tdata));

  inet_checksum #(.AXIS_BYTES(8), .MSB_FIRST(1'b0), .USE_SEED(1'b0), .ZERO_SUB(1'b0)) u_c (
    .clk(clk), .sresetn(sresetn),
    .seed_tvalid(c_seed_tvalid), .seed_tready(c_seed_tready), .seed_tdata(c_seed_tdata),
    .axis_i_tvalid(c_i_tvalid), .axis_i_tready(c_i_tready), .axis_i_tlast(c_i_tlast),
    .axis_i_tkeep(c_i_tkeep), .axis_i_tdata(c_i_tdata),
    .axis_o_tvalid(c_o_tvalid), .axis_o_tready(c_o_tready), .axis_o_tlast(c_o_tlast),
    .axis_o_tdata(c_o_tdata));

  int n_chk;
  int n_fail;
  int c_drv_timeouts;
  logic [15:0] c_expq[$];

  typedef struct {
    logic [31:0] by;    // packet bytes, byte 0 in [31:24]
    int          len;
    logic [15:0] exp;
    int          hold;
  } vec_t;
  vec_t va[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic o_valid(input int inst);
    case (inst)
      0:       return a_o_tvalid;
      1:       return b_o_tvalid;
      default: return c_o_tvalid;
    endcase
  endfunction

  function automatic logic [15:0] o_data(input int inst);
    case (inst)
      0:       return a_o_tdata;
      1:       return b_o_tdata;
      default: return c_o_tdata;
    endcase
  endfunction

  function automatic logic i_ready(input int inst);
    case (inst)
      0:       return a_i_tready;
      1:       return b_i_tready;
      default: return c_i_tready;
    endcase
  endfunction

  task automatic set_oready(input int inst, input logic v);
    case (inst)
      0:       a_o_tready = v;
      1:       b_o_tready = v;
      default: c_o_tready = v;
    endcase
  endtask

  // Called right after the edge that took the last beat: result must appear two edges later.
  task automatic collect(input int inst, input string name, input logic [15:0] exp, input int hold);
    int lat;
    lat = 0;
    while (!o_valid(inst) && lat < 20) begin
      tick();
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'd2);
    for (int h = 0; h < hold; h++) tick();
    check({name, " ready in OUT"}, 32'(i_ready(inst)), 32'd0);
    check({name, " valid held"}, 32'(o_valid(inst)), 32'd1);
    check(name, 32'(o_data(inst)), 32'(exp));
    set_oready(inst, 1'b1);
    tick();
    set_oready(inst, 1'b0);
    check({name, " valid drop"}, 32'(o_valid(inst)), 32'd0);
  endtask

  task automatic a_beat(input logic [15:0] d, input logic [1:0] k, input logic l, output int waits);
    a_i_tdata  = d;
    a_i_tkeep  = k;
    a_i_tlast  = l;
    a_i_tvalid = 1'b1;
    waits = 0;
    while (!a_i_tready && waits < 50) begin
      tick();
      waits++;
    end
    tick();
    a_i_tvalid = 1'b0;
  endtask

  // Missing bytes are driven as 0xAA with keep low so they must be ignored.
  task automatic send_a(input string name, input logic [31:0] by, input int len,
                        input logic [15:0] exp, input int hold);
    int nb, w, wsum, idx;
    logic [15:0] d;
    logic [1:0]  k;
    nb   = (len == 0) ? 1 : (len + 1) / 2;
    wsum = 0;
    for (int b = 0; b < nb; b++) begin
      d = 16'hAAAA;
      k = 2'b00;
      for (int h = 0; h < 2; h++) begin
        idx = 2 * b + h;
        if (idx < len) begin
          k[h] = 1'b1;
          if (h == 0) d[15:8] = by[31-8*idx -: 8];
          else        d[7:0]  = by[31-8*idx -: 8];
        end
      end
      a_beat(d, k, (b == nb - 1), w);
      wsum += w;
    end
    check({name, " no bubbles"}, 32'(wsum), 32'd0);
    collect(0, name, exp, hold);
  endtask

  // Data is presented before the seed and must stall until the seed is taken.
  task automatic send_b(input string name, input logic [15:0] seed, input logic [15:0] word,
                        input logic [15:0] exp, input int pre);
    int w;
    b_i_tdata  = word;
    b_i_tkeep  = 2'b11;
    b_i_tlast  = 1'b1;
    b_i_tvalid = 1'b1;
    for (int p = 0; p < pre; p++) begin
      check({name, " data stalled"}, 32'(b_i_tready), 32'd0);
      tick();
    end
    b_seed_tdata  = seed;
    b_seed_tvalid = 1'b1;
    w = 0;
    while (!b_seed_tready && w < 50) begin
      tick();
      w++;
    end
    check({name, " seed ready"}, 32'(b_seed_tready), 32'd1);
    tick();
    b_seed_tvalid = 1'b0;
    check({name, " readies exclusive"}, 32'(b_seed_tready & b_i_tready), 32'd0);
    w = 0;
    while (!b_i_tready && w < 50) begin
      tick();
      w++;
    end
    check({name, " data ready"}, 32'(b_i_tready), 32'd1);
    tick();
    b_i_tvalid = 1'b0;
    collect(1, name, exp, 1);
  endtask

  task automatic c_driver();
    logic [7:0] pk [64];
    int len, nb, s, w;
    for (int p = 0; p < 100; p++) begin
      len = $urandom_range(64, 1);
      s = 0;
      for (int i = 0; i < len; i++) begin
        pk[i] = 8'($urandom);
        s += ((i % 2) == 0) ? (int'(pk[i]) << 8) : int'(pk[i]);
      end
      while (s > 32'h0000FFFF) s = (s & 32'h0000FFFF) + (s >> 16);
      c_expq.push_back(~16'(s));
      nb = (len + 7) / 8;
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(2, 0)) tick();
        for (int k = 0; k < 8; k++) begin
          if (8 * b + k < len) begin
            c_i_tdata[8*k +: 8] = pk[8*b+k];
            c_i_tkeep[k]        = 1'b1;
          end else begin
            c_i_tdata[8*k +: 8] = 8'($urandom);
            c_i_tkeep[k]        = 1'b0;
          end
        end
        c_i_tlast  = (b == nb - 1);
        c_i_tvalid = 1'b1;
        w = 0;
        while (!c_i_tready && w < 200) begin
          tick();
          w++;
        end
        if (w >= 200) c_drv_timeouts++;
        tick();
        c_i_tvalid = 1'b0;
      end
    end
  endtask

  task automatic c_monitor();
    int t, hold, viol;
    logic [15:0] exp;
    viol = 0;
    for (int n = 0; n < 100; n++) begin
      t = 0;
      while (!c_o_tvalid && t < 3000) begin
        tick();
        t++;
      end
      if (t >= 3000) begin
        check($sformatf("C pkt %0d timeout", n), 32'(t), 32'd0);
        break;
      end
      exp = 16'h0000;
      if (c_expq.size() > 0) exp = c_expq.pop_front();
      hold = $urandom_range(5, 0);
      for (int h = 0; h < hold; h++) begin
        if (c_i_tready || !c_o_tvalid || (c_o_tdata !== exp)) viol++;
        tick();
      end
      if (c_i_tready) viol++;
      c_o_tready = 1'b1;
      check($sformatf("C pkt %0d", n), 32'(c_o_tdata), 32'(exp));
      tick();
      c_o_tready = 1'b0;
    end
    check("C no accept in OUT / stable output", 32'(viol), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, seen;
    n_chk = 0;
    n_fail = 0;
    c_drv_timeouts = 0;
    {a_seed_tvalid, a_i_tvalid, a_i_tlast, a_o_tready} = '0;
    {b_seed_tvalid, b_i_tvalid, b_i_tlast, b_o_tready} = '0;
    {c_seed_tvalid, c_i_tvalid, c_i_tlast, c_o_tready} = '0;
    a_seed_tdata = '0; a_i_tdata = '0; a_i_tkeep = '0;
    b_seed_tdata = '0; b_i_tdata = '0; b_i_tkeep = '0;
    c_seed_tdata = '0; c_i_tdata = '0; c_i_tkeep = '0;

    va[0] = '{32'h0102_0300, 3, 16'hFBFD, 0};
    va[1] = '{32'hFFFF_0002, 4, 16'hFFFD, 1};
    va[2] = '{32'hFFFF_0000, 2, 16'h0000, 2};
    va[3] = '{32'h0001_0000, 2, 16'hFFFE, 0};
    va[4] = '{32'h0000_0000, 0, 16'hFFFF, 3};
    va[5] = '{32'h1234_5678, 4, 16'h9753, 0};
    va[6] = '{32'h8000_0000, 1, 16'h7FFF, 1};
    va[7] = '{32'hFFFF_FFFF, 4, 16'h0000, 0};
    va[8] = '{32'hABCD_EF00, 3, 16'h6531, 2};

    sresetn = 1'b0;
    repeat (3) tick();
    sresetn = 1'b1;

    check("A reset o_tvalid", 32'(a_o_tvalid), 32'd0);
    check("A reset i_tready", 32'(a_i_tready), 32'd1);
    check("A reset seed_tready", 32'(a_seed_tready), 32'd0);
    check("A reset o_tdata", 32'(a_o_tdata), 32'h0000FFFF);
    check("A reset o_tlast", 32'(a_o_tlast), 32'd1);
    check("B reset i_tready", 32'(b_i_tready), 32'd0);
    check("B reset seed_tready", 32'(b_seed_tready), 32'd1);
    check("B reset o_tvalid", 32'(b_o_tvalid), 32'd0);
    check("C reset i_tready", 32'(c_i_tready), 32'd1);
    check("C reset o_tdata", 32'(c_o_tdata), 32'h0000FFFF);

    for (int i = 0; i < 9; i++) begin
      send_a($sformatf("A vec %0d", i), va[i].by, va[i].len, va[i].exp, va[i].hold);
    end

    // Trailing beat with tkeep all zero contributes nothing.
    a_beat(16'h0102, 2'b11, 1'b0, w);
    a_beat(16'hBEEF, 2'b00, 1'b1, w);
    collect(0, "A empty last beat", 16'hFEFD, 0);

    send_b("B seed 1234", 16'h1234, 16'h0001, 16'hEDCA, 3);
    send_b("B zero sub", 16'h0000, 16'hFFFF, 16'hFFFF, 1);
    send_b("B seed carry", 16'hFFFF, 16'h0001, 16'hFFFE, 0);

    // RFC 1071 example bytes 00 01 F2 03 F4 F5 F6 F7 in one LSB-first beat.
    c_i_tdata  = 64'hF7F6_F5F4_03F2_0100;
    c_i_tkeep  = 8'hFF;
    c_i_tlast  = 1'b1;
    c_i_tvalid = 1'b1;
    w = 0;
    while (!c_i_tready && w < 50) begin
      tick();
      w++;
    end
    tick();
    c_i_tvalid = 1'b0;
    collect(2, "C rfc1071", 16'h220D, 1);

    fork
      c_driver();
      c_monitor();
    join
    check("C driver timeouts", 32'(c_drv_timeouts), 32'd0);
    check("C expected queue drained", 32'(c_expq.size()), 32'd0);

    // Reset in the middle of a packet abandons it.
    a_beat(16'h1111, 2'b11, 1'b0, w);
    a_beat(16'h2222, 2'b11, 1'b0, w);
    a_beat(16'h3333, 2'b11, 1'b0, w);
    sresetn = 1'b0;
    tick();
    sresetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (a_o_tvalid) seen++;
      tick();
    end
    check("A mid-packet reset no output", 32'(seen), 32'd0);
    check("A post-reset o_tdata", 32'(a_o_tdata), 32'h0000FFFF);
    send_a("A post-reset packet", 32'h0001_0000, 2, 16'hFFFE, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inet_checksum.md
# inet_checksum

Parametrised Internet (RFC 1071) ones'-complement checksum engine for the network stack. It consumes an AXI-Stream packet natively at AXIS_BYTES per beat, with no width converter. It supports odd-length packets via tkeep and an optional per-packet seed, which carries the UDP/TCP pseudo-header partial sum. It emits one 16-bit checksum beat per packet and is the successor to the fixed two-byte UDP checksum path in the UDP/IP transmit and receive-verify pipelines.

## Interface
- AXIS_BYTES, 2: input beat width in bytes; even, 2..16.
- MSB_FIRST, 0: 1 = byte 0 in tdata[8*AXIS_BYTES-1 -: 8]; 0 = byte 0 in tdata[7:0].
- USE_SEED, 0: 1 = one seed beat consumed per packet before data; 0 = seed is 0 and seed_tready is tied 0.
- ZERO_SUB, 0: 1 = a computed 0x0000 result is output as 0xFFFF (UDP rule).
- Reset: sresetn, synchronous, active-low; clock: clk.
- clk  in  1  clock.
- sresetn  in  1  synchronous active-low reset.
- seed_tvalid  in  1  seed valid.
- seed_tready  out  1  seed accepted.
- seed_tdata  in  16  initial 16-bit partial sum.
- axis_i_tvalid  in  1  data valid.
- axis_i_tready  out  1  data ready.
- axis_i_tlast  in  1  last beat of packet.
- axis_i_tkeep  in  AXIS_BYTES  byte enables; bit k refers to byte k; all-ones except on the last beat; contiguous from bit 0.
- axis_i_tdata  in  8*AXIS_BYTES  packet bytes.
- axis_o_tvalid  out  1  checksum valid.
- axis_o_tready  in  1  checksum accepted.
- axis_o_tlast  out  1  constant 1.
- axis_o_tdata  out  16  ones'-complement checksum.

## Operation
- States: SEED, CALC, FOLD1, FOLD2, OUT.
- Reset state is SEED if USE_SEED, else CALC.
- SEED: seed_tready=1. On handshake, acc <= seed_tdata and go to CALC.
- CALC: axis_i_tready=1. Each accepted beat:
  - Zero the bytes whose tkeep bit is 0.
  - Form AXIS_BYTES/2 16-bit words: word j = {byte 2j, byte 2j+1}, with byte 2j as the high octet.
  - Odd final length: the missing low octet is zero (RFC padding).
  - Update acc <= acc[31:16] + acc[15:0] + sum of words. acc is 32 bits wide; this partial fold guarantees no overflow.
  - A beat with tlast moves the block to FOLD1.
- FOLD1: acc <= acc[31:16] + acc[15:0]. FOLD2 repeats the same fold; the result fits in 16 bits.
- OUT:
  - axis_o_tvalid=1.
  - axis_o_tdata = ~acc[15:0]. With ZERO_SUB, a result of 0x0000 is replaced by 0xFFFF.
  - Data is held stable until axis_o_tready.
  - On handshake: clear acc to 0, then go to SEED/CALC.
- A packet with a tlast beat whose tkeep is 0 is legal; that beat contributes 0.
- Non-contiguous tkeep, or a partial tkeep on a non-last beat: output undefined, no hang.
- seed_tready and axis_i_tready are never high in the same cycle.

## Timing
- Reset values:
  - axis_o_tvalid=0.
  - axis_i_tready=1 if !USE_SEED, else 0.
  - seed_tready=USE_SEED.
  - acc=0.
  - axis_o_tdata=0xFFFF, derived from acc=0.
  - axis_o_tlast=1.
- Throughput: one data beat per cycle in CALC, zero bubbles within a packet.
- Latency: last beat accepted in cycle N → FOLD1 in N+1, FOLD2 in N+2 → axis_o_tvalid high in N+3.
- Output handshake in cycle M → next seed/data accepted from cycle M+1. Per-packet overhead is 3 cycles plus the seed beat.
- Readies are registered-state decodes with no combinational path from any tvalid/tready.
- Reset mid-packet or mid-OUT: the packet is abandoned and no checksum is emitted. Same-cycle reset dominates all handshakes.

## Test plan
- RFC 1071 vector, AXIS_BYTES=4, MSB_FIRST=1, USE_SEED=0: beats 0x0001F203, 0xF4F5F6F7(tlast) → 0x220D, valid 3 cycles after the last beat.
- Odd length, AXIS_BYTES=2, MSB_FIRST=1: 0x0102, then 0x03AA with tkeep=01 and tlast → 0xFBFD. The 0xAA byte must be ignored.
- Carry wrap: 0xFFFF, then 0x0002 (tlast) → 0xFFFD. With ZERO_SUB=1, a single beat 0xFFFF (tlast) → 0xFFFF; with ZERO_SUB=0 → 0x0000.
- Seed, USE_SEED=1: seed 0x1234, then data 0x0001 (tlast) → 0xEDCA. The data stream presented before the seed handshake must stall with tready=0.
- Backpressure and back-to-back traffic, AXIS_BYTES=8, MSB_FIRST=0:
  - 100 random packets of 1-64 bytes with random tvalid gaps and axis_o_tready held low for 0-5 cycles.
  - Every result must match the software model.
  - No input is accepted while in OUT.
- Reset mid-packet: assert sresetn=0 for one cycle after 3 beats → no output beat. The next packet 0x0001 (tlast) → 0xFFFE.
